// File: rtl/ysyx_24080006_axi_rd_slv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24080006_axi_rd_slv_pkg
//  Description : Shared types and constants for the AXI4 read-channel
//                responder: burst encodings, response codes, FSM states and
//                the AR/R channel bundles.
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_24080006_axi_rd_slv_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_READ = 2'd2,
        S_RESP = 2'd3
    } rd_slv_fsm_e;

    // Master -> slave: AR channel plus R-channel ready
    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    // Slave -> master: AR ready plus R channel
    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic [3:0]  rid;
    } axi_r_s2m_t;

    // A burst is legal when its type is defined, beats are at most one word
    // wide and WRAP lengths are 2, 4, 8 or 16 beats.
    function automatic logic burst_legal(input logic [1:0] burst,
                                         input logic [2:0] size,
                                         input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst != 2'b11) && (size <= 3'd2) &&
               !((burst == AXI_BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24080006_axi_rd_slv_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24080006_axi_rd_slv_if
//  Description : AXI4 read-channel bundle (AR + R) between an initiator and
//                the read responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface ysyx_24080006_axi_rd_slv_if;
    import ysyx_24080006_axi_rd_slv_pkg::*;

    axi_r_m2s_t r_m2s;
    axi_r_s2m_t r_s2m;

    modport master (output r_m2s, input  r_s2m);
    modport slave  (input  r_m2s, output r_s2m);

endinterface
`default_nettype wire

// File: rtl/ysyx_24080006_axi_rd_slv_burst_addr.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24080006_axi_rd_slv_burst_addr
//  Description : Combinational burst address stepper. Produces the address of
//                the following beat and the response code for both the
//                current beat and the following beat (legality + range).
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_24080006_axi_rd_slv_burst_addr
    import ysyx_24080006_axi_rd_slv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic [1:0]  resp,
    output logic [1:0]  next_resp
);

    // Window size in bytes; 33 bits so BASE_ADDR + span never overflows
    localparam logic [32:0] C_SPAN = 33'(DEPTH) << 2;

    logic [31:0] w_step;
    logic [31:0] w_mask;
    logic [31:0] w_inc;
    logic        w_legal;

    // Address is inside the memory window when its offset from the base,
    // taken without wrap-around, is smaller than the window span
    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < C_SPAN);
    endfunction

    // Next-beat address for FIXED / INCR / WRAP, then classify both beats
    always_comb begin
        w_step  = 32'd1 << size;
        w_mask  = ((32'(len) + 32'd1) << size) - 32'd1;
        w_inc   = addr + w_step;
        w_legal = burst_legal(burst, size, len);
        case (burst)
            AXI_BURST_INCR: next_addr = w_inc;
            AXI_BURST_WRAP: next_addr = (addr & ~w_mask) | (w_inc & w_mask);
            default:        next_addr = addr;
        endcase
        if (!w_legal) begin
            resp      = AXI_RESP_SLVERR;
            next_resp = AXI_RESP_SLVERR;
        end else begin
            resp      = in_range(addr)      ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            next_resp = in_range(next_addr) ? AXI_RESP_OKAY : AXI_RESP_DECERR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_24080006_axi_rd_slv.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24080006_axi_rd_slv
//  Description : AXI4 read responder in front of a synchronous single-port
//                SRAM/ROM. Single outstanding burst, optional wait latency,
//                one beat per cycle, per-beat SLVERR/DECERR.
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_24080006_axi_rd_slv
    import ysyx_24080006_axi_rd_slv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    ysyx_24080006_axi_rd_slv_if.slave  axi,
    output logic                       mem_en,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    input  logic [31:0]                mem_rdata
);

    localparam int AW = $clog2(DEPTH);

    rd_slv_fsm_e state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic [3:0]  id_q,       id_d;
    logic [7:0]  len_q,      len_d;
    logic [2:0]  size_q,     size_d;
    logic [1:0]  burst_q,    burst_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        arready_q,  arready_d;
    logic        rvalid_q,   rvalid_d;
    logic [1:0]  rresp_q,    rresp_d;
    logic        rlast_q,    rlast_d;

    logic [31:0] w_next_addr;
    logic [1:0]  w_cur_resp;
    logic [1:0]  w_next_resp;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_sel_next;
    logic [31:0] w_mem_byte;

    ysyx_24080006_axi_rd_slv_burst_addr #(
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) u_burst_addr (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (w_next_addr),
        .resp      (w_cur_resp),
        .next_resp (w_next_resp)
    );

    assign w_ar_hs = axi.r_m2s.arvalid & arready_q;
    assign w_r_hs  = rvalid_q & axi.r_m2s.rready;

    // Next-state logic; the SRAM is read one cycle ahead of each beat, so on
    // an R handshake the following beat's address is presented immediately
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        mem_en     = 1'b0;
        w_sel_next = 1'b0;
        case (state_q)
            S_IDLE: begin
                arready_d = 1'b1;
                if (w_ar_hs) begin
                    addr_d     = axi.r_m2s.araddr;
                    id_d       = axi.r_m2s.arid;
                    len_d      = axi.r_m2s.arlen;
                    size_d     = axi.r_m2s.arsize;
                    burst_d    = axi.r_m2s.arburst;
                    beat_cnt_d = 8'd0;
                    arready_d  = 1'b0;
                    if (LATENCY > 0) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = 8'(LATENCY - 1);
                    end else begin
                        state_d    = S_READ;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 8'd0) begin
                    state_d = S_READ;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            S_READ: begin
                mem_en   = (w_cur_resp == AXI_RESP_OKAY);
                state_d  = S_RESP;
                rvalid_d = 1'b1;
                rresp_d  = w_cur_resp;
                rlast_d  = (beat_cnt_q == len_q);
            end
            S_RESP: begin
                if (w_r_hs) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = AXI_RESP_OKAY;
                        arready_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        addr_d     = w_next_addr;
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        mem_en     = (w_next_resp == AXI_RESP_OKAY);
                        w_sel_next = 1'b1;
                        rresp_d    = w_next_resp;
                        rlast_d    = ((beat_cnt_q + 8'd1) == len_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Word index of the beat being fetched; low bits below a word are dropped
    assign w_mem_byte = (w_sel_next ? w_next_addr : addr_q) - BASE_ADDR;
    assign mem_addr   = AW'(w_mem_byte >> 2);

    // State, burst context and R-channel registers; reset aborts any burst
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            id_q       <= 4'd0;
            len_q      <= 8'd0;
            size_q     <= 3'd0;
            burst_q    <= 2'd0;
            beat_cnt_q <= 8'd0;
            wait_cnt_q <= 8'd0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= AXI_RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    // SRAM output holds while mem_en is low, so it can feed rdata directly
    assign axi.r_s2m = '{
        arready: arready_q,
        rvalid:  rvalid_q,
        rdata:   (rvalid_q && (rresp_q == AXI_RESP_OKAY)) ? mem_rdata : 32'd0,
        rresp:   rresp_q,
        rlast:   rlast_q,
        rid:     id_q
    };

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080006_axi_rd_slv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24080006_axi_rd_slv
//  Description : Directed self-checking bench for the AXI4 read responder.
//                Instance 0 runs with no wait latency, instance 1 with five
//                wait cycles. Each SRAM word reads back as C0DE_0000 | index.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_24080006_axi_rd_slv;
    import ysyx_24080006_axi_rd_slv_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          DEP  = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    axi_r_m2s_t  m2s [2];
    axi_r_s2m_t  s2m [2];
    logic        mem_en   [2];
    logic [9:0]  mem_addr [2];
    logic [31:0] mem_rdata[2];
    int          men_tot  [2];

    int          t_ar, ar_wait, men_base, nb, nv;
    logic [31:0] b_data [16];
    logic [1:0]  b_resp [16];
    logic        b_last [16];
    logic [3:0]  b_rid  [16];
    int          b_cyc  [16];
    logic [31:0] v_data [16];
    logic        v_last [16];

    ysyx_24080006_axi_rd_slv_if bus0 ();
    ysyx_24080006_axi_rd_slv_if bus1 ();

    assign bus0.r_m2s = m2s[0];
    assign bus1.r_m2s = m2s[1];
    assign s2m[0]     = bus0.r_s2m;
    assign s2m[1]     = bus1.r_s2m;

    ysyx_24080006_axi_rd_slv #(.BASE_ADDR(BASE), .DEPTH(DEP), .LATENCY(0)) u_dut0 (
        .clock(clock), .reset(reset), .axi(bus0),
        .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]));

    ysyx_24080006_axi_rd_slv #(.BASE_ADDR(BASE), .DEPTH(DEP), .LATENCY(5)) u_dut1 (
        .clock(clock), .reset(reset), .axi(bus1),
        .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]));

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous SRAM models: data next cycle, held while not enabled
    always @(posedge clock) begin
        if (mem_en[0]) mem_rdata[0] <= 32'hC0DE_0000 | 32'(mem_addr[0]);
        if (mem_en[1]) mem_rdata[1] <= 32'hC0DE_0000 | 32'(mem_addr[1]);
        if (mem_en[0]) men_tot[0] <= men_tot[0] + 1;
        if (mem_en[1]) men_tot[1] <= men_tot[1] + 1;
    end

    function automatic logic [31:0] wrd(input int idx);
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Present an AR request, wait for acceptance, record handshake cycle
    task automatic ar_send(input int sel, input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int guard = 0;
        @(negedge clock);
        m2s[sel].arvalid = 1'b1;
        m2s[sel].araddr  = addr;
        m2s[sel].arid    = id;
        m2s[sel].arlen   = len;
        m2s[sel].arsize  = size;
        m2s[sel].arburst = burst;
        while (!s2m[sel].arready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("ar_accept", 32'(guard < 50), 32'd1);
        ar_wait  = guard;
        t_ar     = cyc;
        men_base = men_tot[sel];
        @(negedge clock);
        m2s[sel].arvalid = 1'b0;
        check("arready_busy", 32'(s2m[sel].arready), 32'd0);
    endtask

    // Drain R beats; rready follows pat, one bit per rvalid cycle
    task automatic collect(input int sel, input logic [7:0] pat, input int stop_after);
        int   k     = 0;
        int   guard = 0;
        logic done  = 1'b0;
        nb = 0;
        nv = 0;
        while (!done && guard < 200) begin
            @(negedge clock);
            guard++;
            if (s2m[sel].rvalid) begin
                m2s[sel].rready = pat[k % 8];
                k++;
                if (nv < 16) begin
                    v_data[nv] = s2m[sel].rdata;
                    v_last[nv] = s2m[sel].rlast;
                end
                nv++;
                if (m2s[sel].rready && nb < 16) begin
                    b_data[nb] = s2m[sel].rdata;
                    b_resp[nb] = s2m[sel].rresp;
                    b_last[nb] = s2m[sel].rlast;
                    b_rid[nb]  = s2m[sel].rid;
                    b_cyc[nb]  = cyc;
                    nb++;
                    if (s2m[sel].rlast || nb == stop_after) done = 1'b1;
                end
            end else begin
                m2s[sel].rready = 1'b0;
            end
        end
        check("r_complete", 32'(done), 32'd1);
    endtask

    // One cycle after the final beat: ready for a new AR, R idle
    task automatic post_last(input int sel);
        @(negedge clock);
        m2s[sel].rready = 1'b0;
        check("arready_after_last", 32'(s2m[sel].arready), 32'd1);
        check("rvalid_after_last",  32'(s2m[sel].rvalid),  32'd0);
    endtask

    initial begin
        m2s[0] = '0;
        m2s[1] = '0;
        men_tot[0] = 0;
        men_tot[1] = 0;
        mem_rdata[0] = 32'd0;
        mem_rdata[1] = 32'd0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_arready", 32'(s2m[0].arready), 32'd0);
        check("rst_rvalid",  32'(s2m[0].rvalid),  32'd0);
        check("rst_rlast",   32'(s2m[0].rlast),   32'd0);
        check("rst_rresp",   32'(s2m[0].rresp),   32'd0);
        check("rst_rid",     32'(s2m[0].rid),     32'd0);
        check("rst_rdata",   s2m[0].rdata,        32'd0);
        check("rst_mem_en",  32'(mem_en[0]),      32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("arready_after_rst", 32'(s2m[0].arready), 32'd1);

        // 1: INCR x4 words 4..7, one beat per cycle from T+2
        ar_send(0, 32'h3000_0010, 4'h5, 8'd3, 3'd2, AXI_BURST_INCR);
        collect(0, 8'hFF, 0);
        check("t1_nbeats", 32'(nb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", b_data[i], wrd(4 + i));
            check("t1_last", 32'(b_last[i]), 32'(i == 3));
            check("t1_resp", 32'(b_resp[i]), 32'(AXI_RESP_OKAY));
            check("t1_rid",  32'(b_rid[i]), 32'h5);
            check("t1_cyc",  32'(b_cyc[i]), 32'(t_ar + 2 + i));
        end
        check("t1_mem_en_cnt", 32'(men_tot[0] - men_base), 32'd4);
        post_last(0);

        // 2: WRAP x4 from word 6 -> 6,7,4,5
        ar_send(0, 32'h3000_0018, 4'hA, 8'd3, 3'd2, AXI_BURST_WRAP);
        collect(0, 8'hFF, 0);
        check("t2_nbeats", 32'(nb), 32'd4);
        check("t2_d0", b_data[0], wrd(6));
        check("t2_d1", b_data[1], wrd(7));
        check("t2_d2", b_data[2], wrd(4));
        check("t2_d3", b_data[3], wrd(5));
        for (int i = 0; i < 4; i++) check("t2_resp", 32'(b_resp[i]), 32'(AXI_RESP_OKAY));
        check("t2_last", 32'(b_last[3]), 32'd1);
        post_last(0);

        // 3: back-to-back AR, rready 1,0,0,1 stall on INCR x2
        ar_send(0, 32'h3000_0040, 4'h3, 8'd1, 3'd2, AXI_BURST_INCR);
        check("t3_b2b_accept", 32'(ar_wait), 32'd0);
        collect(0, 8'b1001_1001, 0);
        check("t3_nbeats", 32'(nb), 32'd2);
        check("t3_nvalid", 32'(nv), 32'd4);
        check("t3_v0", v_data[0], wrd(16));
        check("t3_v1", v_data[1], wrd(17));
        check("t3_v2", v_data[2], wrd(17));
        check("t3_v3", v_data[3], wrd(17));
        check("t3_l1", 32'(v_last[1]), 32'd1);
        check("t3_l2", 32'(v_last[2]), 32'd1);
        check("t3_l3", 32'(v_last[3]), 32'd1);
        check("t3_mem_en_cnt", 32'(men_tot[0] - men_base), 32'd2);
        post_last(0);

        // 4: crossing the top of the window -> OKAY then DECERR
        ar_send(0, BASE + 32'(4 * DEP) - 32'd4, 4'h1, 8'd1, 3'd2, AXI_BURST_INCR);
        collect(0, 8'hFF, 0);
        check("t4_nbeats", 32'(nb), 32'd2);
        check("t4_d0", b_data[0], wrd(DEP - 1));
        check("t4_r0", 32'(b_resp[0]), 32'(AXI_RESP_OKAY));
        check("t4_d1", b_data[1], 32'd0);
        check("t4_r1", 32'(b_resp[1]), 32'(AXI_RESP_DECERR));
        check("t4_mem_en_cnt", 32'(men_tot[0] - men_base), 32'd1);
        post_last(0);

        // Below base -> DECERR
        ar_send(0, 32'h2FFF_FFFC, 4'h1, 8'd0, 3'd2, AXI_BURST_INCR);
        collect(0, 8'hFF, 0);
        check("below_resp", 32'(b_resp[0]), 32'(AXI_RESP_DECERR));
        check("below_mem_en_cnt", 32'(men_tot[0] - men_base), 32'd0);
        post_last(0);

        // 5a: arsize=3 -> every beat SLVERR
        ar_send(0, 32'h3000_0000, 4'h2, 8'd1, 3'd3, AXI_BURST_INCR);
        collect(0, 8'hFF, 0);
        check("t5a_nbeats", 32'(nb), 32'd2);
        check("t5a_r0", 32'(b_resp[0]), 32'(AXI_RESP_SLVERR));
        check("t5a_r1", 32'(b_resp[1]), 32'(AXI_RESP_SLVERR));
        check("t5a_d0", b_data[0], 32'd0);
        check("t5a_l1", 32'(b_last[1]), 32'd1);
        check("t5a_mem_en_cnt", 32'(men_tot[0] - men_base), 32'd0);
        post_last(0);

        // 5b: WRAP with len=2 -> three SLVERR beats
        ar_send(0, 32'h3000_0000, 4'h2, 8'd2, 3'd2, AXI_BURST_WRAP);
        collect(0, 8'hFF, 0);
        check("t5b_nbeats", 32'(nb), 32'd3);
        for (int i = 0; i < 3; i++) check("t5b_resp", 32'(b_resp[i]), 32'(AXI_RESP_SLVERR));
        check("t5b_l2", 32'(b_last[2]), 32'd1);
        post_last(0);

        // 5c: LATENCY=5 instance -> first rvalid at T+7
        ar_send(1, 32'h3000_0008, 4'h7, 8'd0, 3'd2, AXI_BURST_INCR);
        collect(1, 8'hFF, 0);
        check("t5c_cyc",  32'(b_cyc[0]), 32'(t_ar + 7));
        check("t5c_data", b_data[0], wrd(2));
        check("t5c_last", 32'(b_last[0]), 32'd1);
        post_last(1);

        // 6: reset after beat 1 of a 4-beat burst
        ar_send(0, 32'h3000_0000, 4'h2, 8'd3, 3'd2, AXI_BURST_INCR);
        collect(0, 8'hFF, 2);
        @(negedge clock);
        check("t6_pre_rvalid", 32'(s2m[0].rvalid), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_rvalid",  32'(s2m[0].rvalid),  32'd0);
        check("t6_rst_arready", 32'(s2m[0].arready), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_rel_arready", 32'(s2m[0].arready), 32'd1);
        check("t6_rel_rvalid",  32'(s2m[0].rvalid),  32'd0);
        ar_send(0, 32'h3000_0020, 4'h9, 8'd0, 3'd2, AXI_BURST_INCR);
        collect(0, 8'hFF, 0);
        check("t6_nbeats", 32'(nb), 32'd1);
        check("t6_data", b_data[0], wrd(8));
        check("t6_rid",  32'(b_rid[0]), 32'h9);
        check("t6_cyc",  32'(b_cyc[0]), 32'(t_ar + 2));
        post_last(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
